// File: rtl/risc_v_mike_mmio_master_pkg.sv
// Shared types and constants for the core's data MMIO initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package risc_v_mike_mmio_master_pkg;

    localparam int ADDRESS_32_W = 32;
    localparam int DATA_32_W    = 32;

    // Default MMIO window: 256 bytes starting at 0x1000_0000.
    localparam logic [ADDRESS_32_W-1:0] MMIO_BASE_DEF = 32'h1000_0000;
    localparam logic [ADDRESS_32_W-1:0] MMIO_SIZE_DEF = 32'h0000_0100;

    // RISC-V load/store funct3 encodings.
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } mmio_state_e;

endpackage

// File: rtl/risc_v_mike_mmio_master_if.sv
// Request/response and MMIO bus bundle between memory stage, initiator and decoder.
// Latency: n/a (wires only).
// Backpressure: req_rdy/rsp_rdy valid-ready pairs; the bus side has no stall.
// Ports: master = initiator view (drives req_rdy, rsp_*, data_mmio_* strobes);
//        slave  = environment view (drives requests, rsp_rdy, read data).
interface risc_v_mike_mmio_master_if;
    import risc_v_mike_mmio_master_pkg::*;

    logic                    req_val;
    logic                    req_rdy;
    logic                    req_we;
    logic [2:0]              req_funct3;
    logic [ADDRESS_32_W-1:0] req_addr;
    logic [DATA_32_W-1:0]    req_wdata;
    logic                    rsp_val;
    logic                    rsp_rdy;
    logic [DATA_32_W-1:0]    rsp_rdata;
    logic                    rsp_err;
    logic                    data_mmio_addr_val;
    logic                    data_mmio_wr_en;
    logic [ADDRESS_32_W-1:0] data_mmio_addr;
    logic [DATA_32_W-1:0]    data_mmio_wr_data;
    logic [DATA_32_W-1:0]    data_mmio_rd_data;

    modport master (
        input  req_val, req_we, req_funct3, req_addr, req_wdata, rsp_rdy, data_mmio_rd_data,
        output req_rdy, rsp_val, rsp_rdata, rsp_err,
               data_mmio_addr_val, data_mmio_wr_en, data_mmio_addr, data_mmio_wr_data
    );

    modport slave (
        output req_val, req_we, req_funct3, req_addr, req_wdata, rsp_rdy, data_mmio_rd_data,
        input  req_rdy, rsp_val, rsp_rdata, rsp_err,
               data_mmio_addr_val, data_mmio_wr_en, data_mmio_addr, data_mmio_wr_data
    );

endinterface

// File: rtl/risc_v_mike_mmio_lane_unit.sv
// Byte/halfword lane handling: load extract+extend and store read-modify-write merge.
// Latency: combinational.
// Backpressure: none.
// Ports: i_word/i_lane/i_funct3 -> o_load_data; i_old_word/i_new_data/i_lane/i_funct3 -> o_store_word.
module risc_v_mike_mmio_lane_unit
    import risc_v_mike_mmio_master_pkg::*;
(
    input  logic [DATA_32_W-1:0] i_word,
    input  logic [DATA_32_W-1:0] i_old_word,
    input  logic [DATA_32_W-1:0] i_new_data,
    input  logic [1:0]           i_lane,
    input  logic [2:0]           i_funct3,
    output logic [DATA_32_W-1:0] o_load_data,
    output logic [DATA_32_W-1:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte       = i_word[{i_lane, 3'b000} +: 8];
        // Halfword accesses are aligned, so only lane bit 1 picks the half.
        w_half       = i_lane[1] ? i_word[31:16] : i_word[15:0];
        o_load_data  = i_word;
        o_store_word = i_new_data;

        case (i_funct3)
            MEM_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
            MEM_H:  o_load_data = {{16{w_half[15]}}, w_half};
            MEM_BU: o_load_data = {24'h0, w_byte};
            MEM_HU: o_load_data = {16'h0, w_half};
            default: o_load_data = i_word;
        endcase

        // Peripherals have no byte enables: keep the untouched lanes from the read word.
        case (i_funct3)
            MEM_B: begin
                o_store_word = i_old_word;
                o_store_word[{i_lane, 3'b000} +: 8] = i_new_data[7:0];
            end
            MEM_H: begin
                o_store_word = i_old_word;
                if (i_lane[1]) o_store_word[31:16] = i_new_data[15:0];
                else           o_store_word[15:0]  = i_new_data[15:0];
            end
            default: o_store_word = i_new_data;
        endcase
    end

endmodule

// File: rtl/risc_v_mike_mmio_master.sv
// Data MMIO initiator: checks range/alignment, does RMW for SB/SH, returns extended load data.
// Latency: rsp_val 1 cycle after accept (error), 2 (load, SW), 3 (SB/SH).
// Backpressure: req_rdy only in IDLE; response held stable until rsp_rdy, no queueing.
// Ports: clk, rst (async active-low), mmio (master modport: req/rsp handshake and MMIO bus).
module risc_v_mike_mmio_master
    import risc_v_mike_mmio_master_pkg::*;
#(
    parameter logic [ADDRESS_32_W-1:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter logic [ADDRESS_32_W-1:0] MMIO_SIZE = MMIO_SIZE_DEF
)(
    input  logic                         clk,
    input  logic                         rst,
    risc_v_mike_mmio_master_if.master    mmio
);

    mmio_state_e             r_state;
    mmio_state_e             w_next_state;
    logic                    r_we;
    logic                    r_err;
    logic [2:0]              r_funct3;
    logic [ADDRESS_32_W-1:0] r_addr;
    logic [DATA_32_W-1:0]    r_wdata;
    logic [DATA_32_W-1:0]    r_rdbuf;

    logic                    w_f3_ok;
    logic                    w_misaligned;
    logic                    w_in_window;
    logic                    w_req_err;
    logic [ADDRESS_32_W:0]   w_addr_ext;
    logic [ADDRESS_32_W:0]   w_win_hi;
    logic [ADDRESS_32_W-1:0] w_offset;
    logic [DATA_32_W-1:0]    w_load_data;
    logic [DATA_32_W-1:0]    w_store_word;

    // 33-bit compare so a window ending exactly at 2^32 does not wrap to zero.
    assign w_addr_ext  = {1'b0, mmio.req_addr};
    assign w_win_hi    = {1'b0, MMIO_BASE} + {1'b0, MMIO_SIZE};
    assign w_in_window = (w_addr_ext >= {1'b0, MMIO_BASE}) && (w_addr_ext < w_win_hi);

    always_comb begin
        w_f3_ok      = 1'b0;
        w_misaligned = 1'b0;
        case (mmio.req_funct3)
            MEM_B:  w_f3_ok = 1'b1;
            MEM_H:  begin w_f3_ok = 1'b1;          w_misaligned = mmio.req_addr[0];           end
            MEM_W:  begin w_f3_ok = 1'b1;          w_misaligned = (mmio.req_addr[1:0] != 2'b00); end
            MEM_BU: w_f3_ok = !mmio.req_we;
            MEM_HU: begin w_f3_ok = !mmio.req_we;  w_misaligned = mmio.req_addr[0];           end
            default: w_f3_ok = 1'b0;
        endcase
    end

    assign w_req_err = !w_f3_ok || w_misaligned || !w_in_window;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdbuf  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && mmio.req_val) begin
                r_we     <= mmio.req_we;
                r_err    <= w_req_err;
                r_funct3 <= mmio.req_funct3;
                r_addr   <= mmio.req_addr;
                r_wdata  <= mmio.req_wdata;
            end
            if (r_state == ST_RD) begin
                r_rdbuf <= mmio.data_mmio_rd_data;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mmio.req_val) begin
                    if (w_req_err)                                 w_next_state = ST_RSP;
                    else if (mmio.req_we && mmio.req_funct3 == MEM_W) w_next_state = ST_WR;
                    else                                           w_next_state = ST_RD;
                end
            end
            // Only SB/SH stores pass through RD; they continue to the merged write.
            ST_RD:   w_next_state = r_we ? ST_WR : ST_RSP;
            ST_WR:   w_next_state = ST_RSP;
            ST_RSP:  if (mmio.rsp_rdy) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    risc_v_mike_mmio_lane_unit u_lane (
        .i_word       (r_rdbuf),
        .i_old_word   (r_rdbuf),
        .i_new_data   (r_wdata),
        .i_lane       (r_addr[1:0]),
        .i_funct3     (r_funct3),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    assign w_offset = r_addr - MMIO_BASE;

    // All outputs decode from the state register, so strobes are glitch-free and
    // drop as soon as the asynchronous reset forces IDLE.
    always_comb begin
        mmio.req_rdy            = (r_state == ST_IDLE);
        mmio.rsp_val            = (r_state == ST_RSP);
        mmio.rsp_err            = (r_state == ST_RSP) && r_err;
        mmio.rsp_rdata          = '0;
        mmio.data_mmio_addr_val = (r_state == ST_RD) || (r_state == ST_WR);
        mmio.data_mmio_wr_en    = (r_state == ST_WR);
        mmio.data_mmio_addr     = '0;
        mmio.data_mmio_wr_data  = '0;
        if (r_state == ST_RSP && !r_err && !r_we) begin
            mmio.rsp_rdata = w_load_data;
        end
        if (r_state == ST_RD || r_state == ST_WR) begin
            mmio.data_mmio_addr = w_offset & ~32'h3;
        end
        if (r_state == ST_WR) begin
            mmio.data_mmio_wr_data = w_store_word;
        end
    end

endmodule

// File: tb/tb_risc_v_mike_mmio_master.sv
module tb_risc_v_mike_mmio_master;
    import risc_v_mike_mmio_master_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] SIZE = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    risc_v_mike_mmio_master_if bus ();

    risc_v_mike_mmio_master dut (
        .clk  (clk),
        .rst  (rst_n),
        .mmio (bus)
    );

    // Peripheral model: combinational read, write at the clock edge.
    logic [31:0] mem [64];
    assign bus.data_mmio_rd_data = mem[bus.data_mmio_addr[7:2]];
    always @(posedge clk) begin
        if (rst_n && bus.data_mmio_addr_val && bus.data_mmio_wr_en)
            mem[bus.data_mmio_addr[7:2]] <= bus.data_mmio_wr_data;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed { logic err; logic [31:0] data; } rsp_t;
    typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] data; } acc_t;
    rsp_t rsp_q [$];
    acc_t acc_q [$];
    logic [31:0] shadow [64];

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] s;
        s = w >> (int'(a) * 8);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] old, input logic [31:0] nd,
                                             input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] m;
        m = (f3 == 3'b000) ? (32'h0000_00FF << (int'(a) * 8)) : (32'h0000_FFFF << (int'(a) * 8));
        return (old & ~m) | ((nd << (int'(a) * 8)) & m);
    endfunction

    function automatic logic err_model(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        longint ua;
        ua  = longint'(a);
        bad = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (we && (f3 inside {3'b100, 3'b101})) bad = 1'b1;
        if ((f3 inside {3'b001, 3'b101}) && a[0]) bad = 1'b1;
        if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1'b1;
        if (ua < longint'(BASE) || ua >= longint'(BASE) + longint'(SIZE)) bad = 1'b1;
        return bad;
    endfunction

    // Monitors: every bus access and every response handshake is checked against the queues.
    acc_t ea;
    rsp_t er;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.data_mmio_addr_val) begin
                if (acc_q.size() == 0) chk("bus_unexpected_access", 32'd1, 32'd0);
                else begin
                    ea = acc_q.pop_front();
                    chk("bus_wr_en", {31'h0, bus.data_mmio_wr_en}, {31'h0, ea.wr});
                    chk("bus_addr", bus.data_mmio_addr, ea.addr);
                    if (ea.wr) chk("bus_wr_data", bus.data_mmio_wr_data, ea.data);
                end
            end
            if (bus.rsp_val && bus.rsp_rdy) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    er = rsp_q.pop_front();
                    chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, er.err});
                    chk("rsp_rdata", bus.rsp_rdata, er.data);
                end
            end
        end
    end

    // Pushes the expected bus accesses/response, issues the request and checks latency.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        logic        err;
        logic [31:0] off, merged;
        int          idx, lat, exp_lat;
        err = err_model(we, f3, a);
        off = a - BASE;
        idx = int'(off[7:2]);
        if (err) begin
            rsp_q.push_back('{err: 1'b1, data: 32'h0});
            exp_lat = 1;
        end else if (!we) begin
            acc_q.push_back('{wr: 1'b0, addr: {off[31:2], 2'b00}, data: 32'h0});
            rsp_q.push_back('{err: 1'b0, data: ld_model(shadow[idx], a[1:0], f3)});
            exp_lat = 2;
        end else if (f3 == 3'b010) begin
            acc_q.push_back('{wr: 1'b1, addr: {off[31:2], 2'b00}, data: wd});
            rsp_q.push_back('{err: 1'b0, data: 32'h0});
            shadow[idx] = wd;
            exp_lat = 2;
        end else begin
            merged = st_model(shadow[idx], wd, a[1:0], f3);
            acc_q.push_back('{wr: 1'b0, addr: {off[31:2], 2'b00}, data: 32'h0});
            acc_q.push_back('{wr: 1'b1, addr: {off[31:2], 2'b00}, data: merged});
            rsp_q.push_back('{err: 1'b0, data: 32'h0});
            shadow[idx] = merged;
            exp_lat = 3;
        end
        @(negedge clk);
        for (int k = 0; k < 20 && !bus.req_rdy; k++) @(negedge clk);
        chk({tag, "_req_rdy"}, {31'h0, bus.req_rdy}, 32'd1);
        bus.req_val    = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_val = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.rsp_val) begin lat = k; break; end
        end
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    logic [31:0] held, saved_w0;

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
        rst_n          = 1'b0;
        bus.req_val    = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_rdy    = 1'b1;
        #3;
        chk("rst_req_rdy",   {31'h0, bus.req_rdy}, 32'd1);
        chk("rst_rsp_val",   {31'h0, bus.rsp_val}, 32'd0);
        chk("rst_rsp_err",   {31'h0, bus.rsp_err}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_addr_val",  {31'h0, bus.data_mmio_addr_val}, 32'd0);
        chk("rst_wr_en",     {31'h0, bus.data_mmio_wr_en}, 32'd0);
        chk("rst_addr",      bus.data_mmio_addr, 32'h0);
        chk("rst_wr_data",   bus.data_mmio_wr_data, 32'h0);
        #19 rst_n = 1'b1;

        // Preload and directed cases
        do_req(1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, "sw_pre1");
        do_req(1, 3'b010, 32'h1000_0008, 32'h0BAD_F00D, "sw_pre2");
        do_req(1, 3'b010, 32'h1000_000C, 32'hCAFE_8001, "sw_pre3");
        do_req(1, 3'b010, 32'h1000_00FC, 32'h7F01_02FE, "sw_top");
        do_req(0, 3'b010, 32'h1000_0004, 32'h0, "lw");
        do_req(1, 3'b010, 32'h1000_0004, 32'h8000_0000, "sw_80");
        do_req(0, 3'b000, 32'h1000_0007, 32'h0, "lb_neg");
        do_req(0, 3'b100, 32'h1000_0007, 32'h0, "lbu");
        do_req(1, 3'b010, 32'h1000_0000, 32'h1122_3344, "sw_w0");
        do_req(1, 3'b000, 32'h1000_0001, 32'h0000_00AA, "sb");
        do_req(0, 3'b010, 32'h1000_0000, 32'h0, "lw_after_sb");
        do_req(1, 3'b001, 32'h1000_000E, 32'h0000_1234, "sh_hi");
        do_req(0, 3'b001, 32'h1000_000C, 32'h0, "lh_lo_neg");
        do_req(0, 3'b101, 32'h1000_000C, 32'h0, "lhu_lo");
        do_req(0, 3'b001, 32'h1000_000E, 32'h0, "lh_hi");
        do_req(0, 3'b000, 32'h1000_00FF, 32'h0, "lb_last_byte");
        do_req(1, 3'b010, 32'h1000_0002, 32'h5555_5555, "sw_misaligned");
        do_req(0, 3'b010, 32'h2000_0000, 32'h0, "lw_out_of_window");
        do_req(0, 3'b000, 32'h1000_0100, 32'h0, "lb_past_end");
        do_req(0, 3'b000, 32'h0FFF_FFFF, 32'h0, "lb_below_base");
        do_req(0, 3'b001, 32'h1000_0001, 32'h0, "lh_misaligned");
        do_req(0, 3'b011, 32'h1000_0000, 32'h0, "illegal_f3");
        do_req(1, 3'b100, 32'h1000_0000, 32'h0, "store_bu");

        // Random mix over the preloaded words plus window edges
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0:       a = 32'h1000_0100 + 32'($urandom_range(0, 3));
                1:       a = 32'h0FFF_FFFC + 32'($urandom_range(0, 3));
                default: a = 32'h1000_0000 + 32'($urandom_range(0, 15));
            endcase
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rnd");
        end

        // Response held off: outputs stable, new request ignored
        acc_q.push_back('{wr: 1'b0, addr: 32'h4, data: 32'h0});
        rsp_q.push_back('{err: 1'b0, data: shadow[1]});
        @(negedge clk);
        bus.rsp_rdy    = 1'b0;
        bus.req_val    = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h1000_0004;
        @(posedge clk);
        #1 bus.req_val = 1'b0;
        for (int k = 0; k < 10 && !bus.rsp_val; k++) @(negedge clk);
        chk("hold_rsp_seen", {31'h0, bus.rsp_val}, 32'd1);
        held = bus.rsp_rdata;
        chk("hold_rdata_value", held, shadow[1]);
        bus.req_val    = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h1000_0008;
        bus.req_wdata  = 32'h0000_0055;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_val", {31'h0, bus.rsp_val}, 32'd1);
            chk("hold_rdata",   bus.rsp_rdata, held);
            chk("hold_req_rdy", {31'h0, bus.req_rdy}, 32'd0);
        end
        @(posedge clk);
        #1 bus.rsp_rdy = 1'b1;
        bus.req_val = 1'b0;
        @(negedge clk);
        chk("hs_req_rdy_low", {31'h0, bus.req_rdy}, 32'd0);
        @(negedge clk);
        chk("post_hs_req_rdy", {31'h0, bus.req_rdy}, 32'd1);
        chk("post_hs_rsp_val", {31'h0, bus.rsp_val}, 32'd0);
        chk("hold_no_extra_access", acc_q.size(), 32'd0);
        do_req(0, 3'b010, 32'h1000_0008, 32'h0, "lw_after_ignored_sw");

        // Reset asserted during the WR cycle of an SH
        saved_w0 = shadow[0];
        do_req_abort();
        shadow[0] = saved_w0;
        rsp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("in_rst_req_rdy", {31'h0, bus.req_rdy}, 32'd1);
        chk("in_rst_rsp_val", {31'h0, bus.rsp_val}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_rdy",  {31'h0, bus.req_rdy}, 32'd1);
        chk("post_rst_rsp_val",  {31'h0, bus.rsp_val}, 32'd0);
        chk("post_rst_addr_val", {31'h0, bus.data_mmio_addr_val}, 32'd0);
        do_req(0, 3'b010, 32'h1000_0000, 32'h0, "lw_after_abort");

        @(negedge clk);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        chk("acc_q_drained", acc_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    task automatic do_req_abort();
        logic [31:0] merged;
        merged = st_model(shadow[0], 32'h0000_BEEF, 2'b10, 3'b001);
        acc_q.push_back('{wr: 1'b0, addr: 32'h0, data: 32'h0});
        acc_q.push_back('{wr: 1'b1, addr: 32'h0, data: merged});
        rsp_q.push_back('{err: 1'b0, data: 32'h0});
        @(negedge clk);
        bus.req_val    = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h1000_0002;
        bus.req_wdata  = 32'h0000_BEEF;
        @(posedge clk);
        #1 bus.req_val = 1'b0;
        for (int k = 0; k < 10 && !(bus.data_mmio_addr_val && bus.data_mmio_wr_en); k++) @(negedge clk);
        chk("abort_in_wr", {31'h0, bus.data_mmio_wr_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_addr_val_drop", {31'h0, bus.data_mmio_addr_val}, 32'd0);
        chk("abort_wr_en_drop",    {31'h0, bus.data_mmio_wr_en}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1);
    end

endmodule
